// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: mdOp opcodes, default latencies, FSM state type and opcode classifiers.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu/msub/msubu on codes 9-12).
package mdu_unit_pkg;

    localparam logic [3:0] MDOP_NONE  = 4'd0;
    localparam logic [3:0] MDOP_MULT  = 4'd1;
    localparam logic [3:0] MDOP_MULTU = 4'd2;
    localparam logic [3:0] MDOP_DIV   = 4'd3;
    localparam logic [3:0] MDOP_DIVU  = 4'd4;
    localparam logic [3:0] MDOP_MTHI  = 4'd5;
    localparam logic [3:0] MDOP_MTLO  = 4'd6;
    localparam logic [3:0] MDOP_MFHI  = 4'd7;
    localparam logic [3:0] MDOP_MFLO  = 4'd8;
    localparam logic [3:0] MDOP_MADD  = 4'd9;
    localparam logic [3:0] MDOP_MADDU = 4'd10;
    localparam logic [3:0] MDOP_MSUB  = 4'd11;
    localparam logic [3:0] MDOP_MSUBU = 4'd12;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for MUL_LAT cycles; the accumulate forms exist only when enabled.
    function automatic logic isMulOp(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MDOP_MULT) || (op == MDOP_MULTU) || (op == MDOP_MADD) ||
               (op == MDOP_MADDU) || (op == MDOP_MSUB) || (op == MDOP_MSUBU);
`else
        return (op == MDOP_MULT) || (op == MDOP_MULTU);
`endif
    endfunction

    function automatic logic isDivOp(input logic [3:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU arithmetic: one shared multiplier and a sign-magnitude divider feeding pending HI/LO.
// Optional feature macro: MDU_MADD_EN (accumulate the product onto the incoming HI/LO).
module mdu_calc
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       mdOp_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] pendHi_o,
    output logic [WIDTH-1:0] pendLo_o,
    output logic             div0_o
);

    logic               mulSigned;
    logic [2*WIDTH-1:0] aExt;
    logic [2*WIDTH-1:0] bExt;
    logic [2*WIDTH-1:0] product;

    logic               divSigned;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   qMag;
    logic [WIDTH-1:0]   rMag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier give the correct low 2*WIDTH bits for both signednesses.
    always_comb begin
        mulSigned = (mdOp_i == MDOP_MULT) || (mdOp_i == MDOP_MADD) || (mdOp_i == MDOP_MSUB);
        aExt      = {{WIDTH{mulSigned & a_i[WIDTH-1]}}, a_i};
        bExt      = {{WIDTH{mulSigned & b_i[WIDTH-1]}}, b_i};
        product   = aExt * bExt;
    end

    // Divide magnitudes, then restore signs; MIN_INT / -1 wraps back to MIN_INT with a zero remainder.
    always_comb begin
        divSigned = (mdOp_i == MDOP_DIV);
        aNeg      = divSigned & a_i[WIDTH-1];
        bNeg      = divSigned & b_i[WIDTH-1];
        aMag      = aNeg ? (~a_i + 1'b1) : a_i;
        bMag      = bNeg ? (~b_i + 1'b1) : b_i;
        div0_o    = isDivOp(mdOp_i) && (b_i == '0);
        divisor   = div0_o ? {{(WIDTH-1){1'b0}}, 1'b1} : bMag;
        qMag      = aMag / divisor;
        rMag      = aMag % divisor;
        quot      = (aNeg ^ bNeg) ? (~qMag + 1'b1) : qMag;
        rem       = aNeg ? (~rMag + 1'b1) : rMag;
    end

    always_comb begin
        {pendHi_o, pendLo_o} = {hi_i, lo_i};
        case (mdOp_i)
            MDOP_MULT, MDOP_MULTU: {pendHi_o, pendLo_o} = product;
            MDOP_DIV, MDOP_DIVU:   {pendHi_o, pendLo_o} = {rem, quot};
`ifdef MDU_MADD_EN
            MDOP_MADD, MDOP_MADDU: {pendHi_o, pendLo_o} = {hi_i, lo_i} + product;
            MDOP_MSUB, MDOP_MSUBU: {pendHi_o, pendLo_o} = {hi_i, lo_i} - product;
`endif
            default:               {pendHi_o, pendLo_o} = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency FSM/counter owning the architectural HI/LO registers.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu, run with MUL_LAT).
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [3:0]       mdOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] rd
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] pendHi_q;
    logic [WIDTH-1:0] pendLo_q;
    logic             pendDiv0_q;

    logic [WIDTH-1:0] pendHi_d;
    logic [WIDTH-1:0] pendLo_d;
    logic             div0_d;
    logic             accept;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .mdOp_i   (mdOp),
        .a_i      (A),
        .b_i      (B),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .pendHi_o (pendHi_d),
        .pendLo_o (pendLo_d),
        .div0_o   (div0_d)
    );

    assign accept = start && !cancel && (state_q == ST_IDLE);

    // The result is computed at the start edge, so HI/LO stay architecturally stable for the whole RUN window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pendHi_q   <= '0;
            pendLo_q   <= '0;
            pendDiv0_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (isMulOp(mdOp) || isDivOp(mdOp)) begin
                            pendHi_q   <= pendHi_d;
                            pendLo_q   <= pendLo_d;
                            pendDiv0_q <= div0_d;
                            cnt_q      <= isDivOp(mdOp) ? DIV_CNT : MUL_CNT;
                            state_q    <= ST_RUN;
                        end else if (mdOp == MDOP_MTHI) begin
                            hi_q <= A;
                        end else if (mdOp == MDOP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        if (!pendDiv0_q) begin
                            hi_q <= pendHi_q;
                            lo_q <= pendLo_q;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        rd = '0;
        if (mdOp == MDOP_MFHI) begin
            rd = hi_q;
        end else if (mdOp == MDOP_MFLO) begin
            rd = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, signed/unsigned arithmetic, divide edge cases,
// mthi/mtlo/mfhi/mflo, cancel, ignored mid-RUN start and asynchronous reset.
module tb_mdu_unit;

    localparam int ML = 5;
    localparam int DL = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [3:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd;

    int checks;
    int errors;

    mdu_unit #(
        .WIDTH   (32),
        .MUL_LAT (ML),
        .DIV_LAT (DL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .mdOp   (mdOp),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .rd     (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op for exactly one rising edge; returns at the negedge of busy cycle 1.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic canc);
        @(negedge clk);
        start  = 1'b1;
        cancel = canc;
        mdOp   = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        mdOp   = OP_NONE;
    endtask

    // Counts consecutive busy negedges from now, bounded so a stuck busy still terminates.
    task automatic countBusy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 00000000", LO); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
        countBusy(n);
        checks++; if (n !== ML) begin errors++; $display("[TB] FAIL mult_busy: got %0d want %0d", n, ML); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h want FFFFFFFF", HI); end
        checks++; if (LO !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_lo: got %h want FFFFFFEB", LO); end
        applyStimulus(OP_MULTU, 32'hFFFFFFFD, 32'd7, 1'b0);
        countBusy(n);
        checks++; if (n !== ML) begin errors++; $display("[TB] FAIL multu_busy: got %0d want %0d", n, ML); end
        checks++; if (HI !== 32'h00000006) begin errors++; $display("[TB] FAIL multu_hi: got %h want 00000006", HI); end
        checks++; if (LO !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL multu_lo: got %h want FFFFFFEB", LO); end
    endtask

    task automatic test_div();
        int n;
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        countBusy(n);
        checks++; if (n !== DL) begin errors++; $display("[TB] FAIL div_busy: got %0d want %0d", n, DL); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h want FFFFFFFD", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi: got %h want FFFFFFFF", HI); end
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 1'b0);
        countBusy(n);
        checks++; if (n !== DL) begin errors++; $display("[TB] FAIL divu_busy: got %0d want %0d", n, DL); end
        checks++; if (LO !== 32'd3) begin errors++; $display("[TB] FAIL divu_lo: got %h want 00000003", LO); end
        checks++; if (HI !== 32'd1) begin errors++; $display("[TB] FAIL divu_hi: got %h want 00000001", HI); end
    endtask

    task automatic test_div_edge();
        int n;
        applyStimulus(OP_MTHI, 32'h11, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h22, 32'd0, 1'b0);
        checks++; if (HI !== 32'h11) begin errors++; $display("[TB] FAIL seed_hi: got %h want 00000011", HI); end
        checks++; if (LO !== 32'h22) begin errors++; $display("[TB] FAIL seed_lo: got %h want 00000022", LO); end
        applyStimulus(OP_DIV, 32'd5, 32'd0, 1'b0);
        countBusy(n);
        checks++; if (n !== DL) begin errors++; $display("[TB] FAIL div0_busy: got %0d want %0d", n, DL); end
        checks++; if (HI !== 32'h11) begin errors++; $display("[TB] FAIL div0_hi: got %h want 00000011", HI); end
        checks++; if (LO !== 32'h22) begin errors++; $display("[TB] FAIL div0_lo: got %h want 00000022", LO); end
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        countBusy(n);
        checks++; if (n !== DL) begin errors++; $display("[TB] FAIL divovf_busy: got %0d want %0d", n, DL); end
        checks++; if (LO !== 32'h80000000) begin errors++; $display("[TB] FAIL divovf_lo: got %h want 80000000", LO); end
        checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL divovf_hi: got %h want 00000000", HI); end
    endtask

    task automatic test_mthi_mflo();
        logic sawBusy;
        applyStimulus(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        checks++; if (HI !== 32'h1234) begin errors++; $display("[TB] FAIL mthi_hi: got %h want 00001234", HI); end
        sawBusy = busy;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sawBusy = sawBusy | busy;
        end
        checks++; if (sawBusy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b want 0", sawBusy); end
        mdOp = OP_MFLO;
        #1;
        checks++; if (rd !== 32'h80000000) begin errors++; $display("[TB] FAIL mflo_rd: got %h want 80000000", rd); end
        mdOp = OP_MFHI;
        #1;
        checks++; if (rd !== 32'h1234) begin errors++; $display("[TB] FAIL mfhi_rd: got %h want 00001234", rd); end
        mdOp = OP_NONE;
        #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL none_rd: got %h want 00000000", rd); end
    endtask

    task automatic test_cancel_and_ignore();
        int   n;
        logic sawBusy;
        applyStimulus(OP_MULT, 32'd6, 32'd7, 1'b1);
        sawBusy = busy;
        for (int i = 0; i < ML + 1; i++) begin
            @(negedge clk);
            sawBusy = sawBusy | busy;
        end
        checks++; if (sawBusy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_busy: got %b want 0", sawBusy); end
        checks++; if (HI !== 32'h1234) begin errors++; $display("[TB] FAIL cancel_hi: got %h want 00001234", HI); end
        checks++; if (LO !== 32'h80000000) begin errors++; $display("[TB] FAIL cancel_lo: got %h want 80000000", LO); end
        applyStimulus(OP_MULT, 32'd6, 32'd7, 1'b0);
        @(negedge clk);
        start = 1'b1;
        mdOp  = OP_DIV;
        A     = 32'd100;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        mdOp  = OP_NONE;
        countBusy(n);
        checks++; if (n !== ML - 2) begin errors++; $display("[TB] FAIL ignore_busy_rest: got %0d want %0d", n, ML - 2); end
        checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL ignore_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'h2A) begin errors++; $display("[TB] FAIL ignore_lo: got %h want 0000002A", LO); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        applyStimulus(OP_MTHI, 32'hAAAA, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h5555, 32'd0, 1'b0);
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_prebusy: got %b want 1", busy); end
        checks++; if (HI !== 32'hAAAA) begin errors++; $display("[TB] FAIL midrst_prehi: got %h want 0000AAAA", HI); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL midrst_hi: got %h want 00000000", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("[TB] FAIL midrst_lo: got %h want 00000000", LO); end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        countBusy(n);
        checks++; if (n !== ML) begin errors++; $display("[TB] FAIL postrst_busy: got %0d want %0d", n, ML); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL postrst_hi: got %h want FFFFFFFF", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL postrst_lo: got %h want FFFFFFFA", LO); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        mdOp   = OP_NONE;
        A      = 32'h0;
        B      = 32'h0;
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mthi_mflo();
        test_cancel_and_ignore();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
